// File: rtl/pid_pwm_out.sv
// PID actuator stage: scales and clamps the signed control value into a duty count
// and drives an edge-aligned PWM whose duty updates only at period boundaries.
module pid_pwm_out #(
  parameter int CNT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_period,
  input  logic [31:0]      i_un,
  input  logic             i_valid,
  output logic             o_pwm,
  output logic [CNT_W:0]   o_duty,
  output logic             o_sat_hi,
  output logic             o_sat_lo,
  output logic             o_req,
  output logic             o_stale
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W:0]   LIM_ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   duty_pend_q, duty_pend_d;
  logic [CNT_W:0]   duty_act_q, duty_act_d;
  logic             got_q, got_d;
  logic             sat_hi_q, sat_hi_d;
  logic             sat_lo_q, sat_lo_d;
  logic             pwm_q, pwm_d;
  logic             req_q, req_d;
  logic             stale_q, stale_d;

  logic signed [31:0] s;
  logic [CNT_W:0]     lim;
  logic [31:0]        lim_ext;
  logic [CNT_W:0]     clamp_duty;
  logic               clamp_hi, clamp_lo;
  logic               wrap;

  // Scale and clamp into [0, i_period+1]; the limit is zero-extended so the
  // comparison stays signed against a non-negative bound.
  always_comb begin
    s          = $signed(i_un) >>> SHIFT;
    lim        = {1'b0, i_period} + LIM_ONE;
    lim_ext    = {{(31-CNT_W){1'b0}}, lim};
    clamp_duty = s[CNT_W:0];
    clamp_hi   = 1'b0;
    clamp_lo   = 1'b0;
    if (s < 0) begin
      clamp_duty = '0;
      clamp_lo   = 1'b1;
    end else if (s > $signed(lim_ext)) begin
      clamp_duty = lim;
      clamp_hi   = 1'b1;
    end
  end

  always_comb begin
    wrap        = i_en && (cnt_q >= i_period);
    cnt_d       = (!i_en || wrap) ? '0 : cnt_q + CNT_ONE;
    // While disabled the active duty tracks the pending one, so enabling
    // starts straight away with the newest sample.
    duty_act_d  = (!i_en || wrap) ? duty_pend_q : duty_act_q;
    duty_pend_d = duty_pend_q;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
    got_d       = got_q;
    if (wrap)
      got_d = 1'b0;
    if (i_valid) begin
      duty_pend_d = clamp_duty;
      sat_hi_d    = clamp_hi;
      sat_lo_d    = clamp_lo;
      got_d       = 1'b1;
    end
    stale_d = wrap && !got_q && !i_valid;
    pwm_d   = i_en && ({1'b0, cnt_q} < duty_act_q);
    req_d   = i_en && (cnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      got_q       <= 1'b0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
      pwm_q       <= 1'b0;
      req_q       <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      got_q       <= got_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
      pwm_q       <= pwm_d;
      req_q       <= req_d;
      stale_q     <= stale_d;
    end
  end

  assign o_pwm    = pwm_q;
  assign o_duty   = duty_act_q;
  assign o_sat_hi = sat_hi_q;
  assign o_sat_lo = sat_lo_q;
  assign o_req    = req_q;
  assign o_stale  = stale_q;

endmodule
